// File: rtl/stack_engine.sv
// Hardware stack unit: owns SP, sequences 1/2-byte push/pop over a byte memory port,
// bound-checks before any access and keeps sticky overflow/underflow flags.
module stack_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE  = 16'hFFFF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'hFF00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_pop,
  input  logic                cmd_two,
  input  logic [2*DATA_W-1:0] cmd_wdata,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  input  logic                sp_load,
  input  logic [ADDR_W-1:0]   sp_load_val,
  input  logic                clr_flags,
  output logic [ADDR_W-1:0]   sp,
  output logic [ADDR_W-1:0]   depth,
  output logic                empty,
  output logic                full,
  output logic                ovf_flag,
  output logic                unf_flag
);

  localparam logic [ADDR_W-1:0] LIM_M1 = STACK_LIMIT - ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   sp_q;
  logic                beat;
  logic                op_pop, op_two, op_err;
  logic [2*DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic                ovf_q, unf_q;

  logic [ADDR_W:0] free_bytes, used_bytes, n_bytes;
  logic            push_bad, pop_bad, cmd_bad, accept;
  logic            load_ev, load_lo, load_hi;
  logic            last_beat, ovf_set, unf_set;

  // Extra MSB keeps the free/used byte counts from wrapping.
  assign free_bytes = {1'b0, sp_q} - {1'b0, LIM_M1};
  assign used_bytes = {1'b0, STACK_BASE} - {1'b0, sp_q};
  assign n_bytes    = cmd_two ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign push_bad   = n_bytes > free_bytes;
  assign pop_bad    = n_bytes > used_bytes;
  assign cmd_bad    = cmd_pop ? pop_bad : push_bad;
  assign accept     = (state == IDLE) && cmd_valid && !sp_load;
  assign load_ev    = (state == IDLE) && sp_load;
  assign load_lo    = sp_load_val < LIM_M1;
  assign load_hi    = sp_load_val > STACK_BASE;
  assign last_beat  = !op_two || beat;
  assign ovf_set    = (load_ev && load_lo) || (accept && !cmd_pop && push_bad);
  assign unf_set    = (load_ev && load_hi) || (accept && cmd_pop && pop_bad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !sp_load;
        if (accept) state_nxt = cmd_bad ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = !op_pop;
        mem_addr  = op_pop ? sp_q + ADDR_W'(1) : sp_q;
        mem_wdata = (op_two && !beat) ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
        if (mem_ack && last_beat) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = op_err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q    <= STACK_BASE;
      beat    <= 1'b0;
      op_pop  <= 1'b0;
      op_two  <= 1'b0;
      op_err  <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !clr_flags) || ovf_set;
      unf_q <= (unf_q && !clr_flags) || unf_set;
      if (load_ev && !load_lo && !load_hi) sp_q <= sp_load_val;
      if (accept) begin
        op_pop  <= cmd_pop;
        op_two  <= cmd_two;
        op_err  <= cmd_bad;
        wdata_q <= cmd_wdata;
        beat    <= 1'b0;
        if (cmd_bad) rdata_q <= '0;
      end
      if (state == ACCESS && mem_ack) begin
        sp_q <= op_pop ? sp_q + ADDR_W'(1) : sp_q - ADDR_W'(1);
        if (op_pop && !beat) lo_q <= mem_rdata;
        if (!last_beat) beat <= 1'b1;
        // Last byte lands straight in the response register, so RESP needs no extra cycle.
        if (last_beat) begin
          if (!op_pop)     rdata_q <= '0;
          else if (op_two) rdata_q <= {mem_rdata, lo_q};
          else             rdata_q <= {{DATA_W{1'b0}}, mem_rdata};
        end
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign sp        = sp_q;
  assign depth     = STACK_BASE - sp_q;
  assign empty     = sp_q == STACK_BASE;
  assign full      = sp_q == LIM_M1;
  assign ovf_flag  = ovf_q;
  assign unf_flag  = unf_q;

endmodule
